// File: rtl/param_pipelined_alu.sv
// param_pipelined_alu
//   Three-stage pipelined ALU: operand capture -> execute -> write back.
//   All stages advance together whenever the output register is empty or
//   being accepted. Otherwise every stage holds, so a stalled sink
//   back-pressures the operand source through in_ready.
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for A, B, alu_op, in_tag
//   A, B                  operands (B[$clog2(W)-1:0] is the shift amount)
//   alu_op                operation select (0..13 legal, 14..15 illegal)
//   in_tag                sideband tag, returned unchanged with the result
//   out_valid / out_ready output handshake for result, flags, out_tag, out_err
//   result, flags         ALU result and {N, Z, C, V}
//   out_tag, out_err      tag of this result, illegal-opcode indication
module param_pipelined_alu #(
    parameter int unsigned W     = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [3:0]       alu_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [3:0]       flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned SH_W = $clog2(W);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_SRA   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_PASSB = 4'd11,
        OP_INC   = 4'd12,
        OP_DEC   = 4'd13
    } alu_op_e;

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    // Stage 2: executed result
    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     s2_res_q, s2_res_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_err_q, s2_err_d;
    // Stage 3: write-back / output register
    logic             s3_valid_q, s3_valid_d;
    logic [W-1:0]     s3_res_q, s3_res_d;
    logic [3:0]       s3_flags_q, s3_flags_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
    logic             s3_err_q, s3_err_d;

    logic             advance;
    logic [SH_W-1:0]  sh;
    logic [W:0]       add_ext;
    logic [W:0]       shl_ext;
    logic [W:0]       shr_ext;
    logic [W-1:0]     ex_res;
    logic             ex_c, ex_v, ex_err;

    assign advance  = !s3_valid_q || out_ready;
    assign in_ready = advance;
    assign sh       = s1_b_q[SH_W-1:0];

    // Execute. Shifts run on a W+1 bit copy of A so the last bit shifted
    // out lands in the extra bit; with sh=0 that bit is the zero pad.
    always_comb begin
        ex_res  = '0;
        ex_c    = 1'b0;
        ex_v    = 1'b0;
        ex_err  = 1'b0;
        add_ext = '0;
        shl_ext = '0;
        shr_ext = '0;
        case (alu_op_e'(s1_op_q))
            OP_ADD: begin
                add_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                ex_res  = add_ext[W-1:0];
                ex_c    = add_ext[W];
                ex_v    = (s1_a_q[W-1] == s1_b_q[W-1]) && (ex_res[W-1] != s1_a_q[W-1]);
            end
            OP_SUB: begin
                add_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                ex_res  = add_ext[W-1:0];
                ex_c    = add_ext[W];
                ex_v    = (s1_a_q[W-1] != s1_b_q[W-1]) && (ex_res[W-1] != s1_a_q[W-1]);
            end
            OP_INC: begin
                add_ext = {1'b0, s1_a_q} + {1'b0, ONE};
                ex_res  = add_ext[W-1:0];
                ex_c    = add_ext[W];
                ex_v    = (s1_a_q[W-1] == ONE[W-1]) && (ex_res[W-1] != s1_a_q[W-1]);
            end
            OP_DEC: begin
                add_ext = {1'b0, s1_a_q} - {1'b0, ONE};
                ex_res  = add_ext[W-1:0];
                ex_c    = add_ext[W];
                ex_v    = (s1_a_q[W-1] != ONE[W-1]) && (ex_res[W-1] != s1_a_q[W-1]);
            end
            OP_AND:   ex_res = s1_a_q & s1_b_q;
            OP_OR:    ex_res = s1_a_q | s1_b_q;
            OP_XOR:   ex_res = s1_a_q ^ s1_b_q;
            OP_NOT:   ex_res = ~s1_a_q;
            OP_SHL: begin
                shl_ext = {1'b0, s1_a_q} << sh;
                ex_res  = shl_ext[W-1:0];
                ex_c    = shl_ext[W];
            end
            OP_SHR: begin
                shr_ext = {s1_a_q, 1'b0} >> sh;
                ex_res  = shr_ext[W:1];
                ex_c    = shr_ext[0];
            end
            OP_SRA: begin
                shr_ext = $signed({s1_a_q, 1'b0}) >>> sh;
                ex_res  = shr_ext[W:1];
                ex_c    = shr_ext[0];
            end
            OP_SLT:   ex_res[0] = $signed(s1_a_q) < $signed(s1_b_q);
            OP_SLTU:  ex_res[0] = s1_a_q < s1_b_q;
            OP_PASSB: ex_res = s1_b_q;
            default:  ex_err = 1'b1;
        endcase
    end

    // Bubbles shift through like real ops so the latency stays fixed at
    // three advancing cycles regardless of input gaps.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_flags_d = s2_flags_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        s3_valid_d = s3_valid_q;
        s3_res_d   = s3_res_q;
        s3_flags_d = s3_flags_q;
        s3_tag_d   = s3_tag_q;
        s3_err_d   = s3_err_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_a_d     = A;
            s1_b_d     = B;
            s1_op_d    = alu_op;
            s1_tag_d   = in_tag;
            s2_valid_d = s1_valid_q;
            s2_res_d   = ex_res;
            s2_flags_d = {ex_res[W-1], (ex_res == '0), ex_c, ex_v};
            s2_tag_d   = s1_tag_q;
            s2_err_d   = ex_err;
            s3_valid_d = s2_valid_q;
            s3_res_d   = s2_res_q;
            s3_flags_d = s2_flags_q;
            s3_tag_d   = s2_tag_q;
            s3_err_d   = s2_err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_res_q   <= '0;
            s3_flags_q <= '0;
            s3_tag_q   <= '0;
            s3_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
            s3_valid_q <= s3_valid_d;
            s3_res_q   <= s3_res_d;
            s3_flags_q <= s3_flags_d;
            s3_tag_q   <= s3_tag_d;
            s3_err_q   <= s3_err_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign result    = s3_res_q;
    assign flags     = s3_flags_q;
    assign out_tag   = s3_tag_q;
    assign out_err   = s3_err_q;

endmodule

// File: tb/tb_param_pipelined_alu.sv
// Testbench for param_pipelined_alu: directed vectors with hand-computed
// results feed a scoreboard queue; a monitor pops and compares each output.
module tb_param_pipelined_alu;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  fl;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] A = '0, B = '0;
    logic [3:0]  alu_op = '0, in_tag = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] result;
    logic [3:0]  flags, out_tag;
    logic        out_err;

    logic        in_valid32 = 1'b0, in_ready32;
    logic [31:0] A32 = '0, B32 = '0;
    logic [3:0]  op32 = '0, in_tag32 = '0;
    logic        out_valid32;
    logic [31:0] result32;
    logic [3:0]  flags32, out_tag32;
    logic        out_err32;

    always #5 clk = ~clk;

    param_pipelined_alu #(.W(16), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .alu_op(alu_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .out_tag(out_tag), .out_err(out_err)
    );

    param_pipelined_alu #(.W(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(A32), .B(B32), .alu_op(op32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(1'b1), .result(result32),
        .flags(flags32), .out_tag(out_tag32), .out_err(out_err32)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    logic [3:0] tag_ctr = '0;
    vec_t vt[$];
    exp_t sb_q[$];
    exp_t e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] res, input logic [3:0] fl, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl; v.err = err;
        return v;
    endfunction

    always @(negedge clk) begin
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: one output transfer per accepted cycle, checked against the queue head.
    always @(negedge clk) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'(out_tag), 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("flags", 64'(flags), 64'(e.fl));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_err", 64'(out_err), 64'(e.err));
            end
        end
    end

    // Returns just after the posedge on which the operation transferred.
    task automatic send(input vec_t v);
        int t = 0;
        @(negedge clk);
        A = v.a; B = v.b; alu_op = v.op; in_tag = tag_ctr; in_valid = 1'b1;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back({v.res, v.fl, tag_ctr, v.err});
        tag_ctr++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge clk); t++;
        end
        chk("drain_left", 64'(sb_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic latency_check(input string nm);
        int lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk(nm, 64'(lat), 64'd3);
    endtask

    initial begin
        // op, A, B, result, {N,Z,C,V}, err
        vt.push_back(mk(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0)); // ADD overflow
        vt.push_back(mk(4'd1,  16'h0005, 16'h0007, 16'hFFFE, 4'b1010, 1'b0)); // SUB borrow
        vt.push_back(mk(4'd9,  16'hFFFF, 16'h0001, 16'h0001, 4'b0000, 1'b0)); // SLT -1<1
        vt.push_back(mk(4'd8,  16'h8000, 16'h0004, 16'hF800, 4'b1000, 1'b0)); // SRA by 4
        vt.push_back(mk(4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b1)); // illegal
        vt.push_back(mk(4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0)); // AND
        vt.push_back(mk(4'd3,  16'h1200, 16'h0034, 16'h1234, 4'b0000, 1'b0)); // OR
        vt.push_back(mk(4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b0)); // XOR
        vt.push_back(mk(4'd5,  16'h0000, 16'h1111, 16'hFFFF, 4'b1000, 1'b0)); // NOT
        vt.push_back(mk(4'd6,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0)); // SHL carry out
        vt.push_back(mk(4'd7,  16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0)); // SHR carry out
        vt.push_back(mk(4'd7,  16'hABCD, 16'h0010, 16'hABCD, 4'b1000, 1'b0)); // SHR sh=0
        vt.push_back(mk(4'd10, 16'hFFFF, 16'h0001, 16'h0000, 4'b0100, 1'b0)); // SLTU
        vt.push_back(mk(4'd11, 16'h0001, 16'h8000, 16'h8000, 4'b1000, 1'b0)); // PASSB
        vt.push_back(mk(4'd12, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110, 1'b0)); // INC wrap
        vt.push_back(mk(4'd13, 16'h8000, 16'h0000, 16'h7FFF, 4'b0001, 1'b0)); // DEC overflow
        vt.push_back(mk(4'd0,  16'h8000, 16'h8000, 16'h0000, 4'b0111, 1'b0)); // ADD neg overflow
        vt.push_back(mk(4'd13, 16'h0000, 16'h0000, 16'hFFFF, 4'b1010, 1'b0)); // DEC borrow
        vt.push_back(mk(4'd14, 16'h1234, 16'h0001, 16'h0000, 4'b0100, 1'b1)); // illegal
        vt.push_back(mk(4'd9,  16'h8000, 16'h7FFF, 16'h0001, 4'b0000, 1'b0)); // SLT min<max
        vt.push_back(mk(4'd8,  16'hC000, 16'h000F, 16'hFFFF, 4'b1010, 1'b0)); // SRA by 15
        vt.push_back(mk(4'd1,  16'h7FFF, 16'hFFFF, 16'h8000, 4'b1011, 1'b0)); // SUB overflow

        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid32", 64'(out_valid32), 64'd0);
        reset_n = 1'b1;

        // Single op latency, then a back-to-back stream of every vector
        send(vt[0]);
        latency_check("latency_first");
        for (int i = 1; i < vt.size(); i++) send(vt[i]);
        drain();

        // Backpressure: sink stalls once the first result appears
        @(negedge clk);
        or_mode = 2;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(vt[i]);
            end
            begin
                int t = 0;
                @(negedge clk); #1;
                while (!out_valid && t < 20) begin
                    @(negedge clk); #1; t++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    chk("hold_out_valid", 64'(out_valid), 64'd1);
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                    chk("hold_result", 64'(result), 64'(sb_q[0].res));
                    chk("hold_tag", 64'(out_tag), 64'(sb_q[0].tag));
                end
                or_mode = 0;
            end
        join
        drain();

        // Random in_valid gaps and out_ready stalls over the whole table
        or_mode = 1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < vt.size(); i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(vt[i]);
            end
        end
        drain();
        or_mode = 0;
        @(negedge clk);

        // Reset with operations in flight
        send(vt[9]);
        send(vt[6]);
        send(vt[3]);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_flags", 64'(flags), 64'd0);
        chk("midrst_tag", 64'(out_tag), 64'd0);
        chk("midrst_err", 64'(out_err), 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        send(vt[13]);
        latency_check("latency_after_reset");
        drain();

        // 32-bit instance
        @(negedge clk);
        A32 = 32'h8000_0001; B32 = 32'd1; op32 = 4'd6; in_tag32 = 4'd5; in_valid32 = 1'b1;
        @(negedge clk);
        A32 = 32'hFFFF_FFFF; B32 = 32'd1; op32 = 4'd0; in_tag32 = 4'd6;
        @(negedge clk);
        in_valid32 = 1'b0;
        begin
            int t = 0;
            #1;
            while (!out_valid32 && t < 20) begin
                @(negedge clk); #1; t++;
            end
        end
        chk("w32_shl_valid", 64'(out_valid32), 64'd1);
        chk("w32_shl_result", 64'(result32), 64'h0000_0002);
        chk("w32_shl_flags", 64'(flags32), 64'(4'b0010));
        chk("w32_shl_tag", 64'(out_tag32), 64'd5);
        @(negedge clk); #1;
        chk("w32_add_valid", 64'(out_valid32), 64'd1);
        chk("w32_add_result", 64'(result32), 64'h0);
        chk("w32_add_flags", 64'(flags32), 64'(4'b0110));
        chk("w32_add_err", 64'(out_err32), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
